// File: rtl/dcache_pkg.sv
// Shared types, address-split helpers and geometry for the L1 data cache.
// Optional DCACHE_STATS_EN (used by dcache_controller) adds access/miss/write-back counters.
`ifndef DRAM_WORD_SIZE
`define DRAM_WORD_SIZE 32
`endif
`ifndef DRAM_BLOCK_SIZE
`define DRAM_BLOCK_SIZE 4
`endif
`ifndef DCACHE_SIZE
`define DCACHE_SIZE 16
`endif
`ifndef DCACHE_INDEX
`define DCACHE_INDEX $clog2(`DCACHE_SIZE)
`endif

package dcache_pkg;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned WORD_W      = `DRAM_WORD_SIZE;
    localparam int unsigned BLOCK_WORDS = `DRAM_BLOCK_SIZE;
    localparam int unsigned LINES       = `DCACHE_SIZE;
    localparam int unsigned OFF_W       = $clog2(BLOCK_WORDS);
    localparam int unsigned INDEX_W     = `DCACHE_INDEX;
    localparam int unsigned TAG_W       = ADDR_W - INDEX_W - OFF_W - 2;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

    typedef logic [BLOCK_WORDS-1:0][WORD_W-1:0] line_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return TAG_W'(a >> (OFF_W + INDEX_W + 2));
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return INDEX_W'(a >> (OFF_W + 2));
    endfunction

    function automatic logic [OFF_W-1:0] addr_off(input logic [ADDR_W-1:0] a);
        return OFF_W'(a >> 2);
    endfunction

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                    input logic [INDEX_W-1:0] idx);
        return ADDR_W'({tag, idx}) << (OFF_W + 2);
    endfunction
endpackage

// File: rtl/dcache_tag_array.sv
// Per-line tag/valid/dirty storage: one write port, combinational read, valid/dirty
// cleared asynchronously by reset.
module dcache_tag_array
    import dcache_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [TAG_W-1:0]   wtag_i,
    input  logic               wdirty_i,
    output logic [TAG_W-1:0]   rtag_o,
    output logic               rvalid_o,
    output logic               rdirty_o
);
    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q, valid_d;
    logic [LINES-1:0] dirty_q, dirty_d;

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (we_i) begin
            valid_d[index_i] = 1'b1;
            dirty_d[index_i] = wdirty_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tags are meaningless while valid is clear, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) tag_q[index_i] <= wtag_i;
    end

    always_comb begin
        rtag_o   = tag_q[index_i];
        rvalid_o = valid_q[index_i];
        rdirty_o = dirty_q[index_i];
    end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller (FSM, merge mux, DRAM side).
// Define DCACHE_STATS_EN to add access_cnt/miss_cnt/wb_cnt output counters.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [WORD_W-1:0]  cpu_wdata,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic               cpu_ready,
    output logic               sram_we,
    output logic [INDEX_W-1:0] sram_index,
    output line_t              sram_wdata,
    input  line_t              sram_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output line_t              mem_wdata,
    input  line_t              mem_rdata,
    input  logic               mem_ack
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]        access_cnt,
    output logic [31:0]        miss_cnt,
    output logic [31:0]        wb_cnt
`endif
);
    state_e              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    line_t               mem_wdata_q, mem_wdata_d;

    logic [TAG_W-1:0]    cpu_tag, vic_tag;
    logic [INDEX_W-1:0]  idx;
    logic [OFF_W-1:0]    off;
    logic                vic_valid, vic_dirty, hit;
    logic                tag_we, tag_dirty;

    assign cpu_tag    = addr_tag(cpu_addr);
    assign idx        = addr_index(cpu_addr);
    assign off        = addr_off(cpu_addr);
    assign sram_index = idx;
    assign hit        = vic_valid && (vic_tag == cpu_tag);

    dcache_tag_array u_tag_array (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .we_i     (tag_we),
        .index_i  (idx),
        .wtag_i   (cpu_tag),
        .wdirty_i (tag_dirty),
        .rtag_o   (vic_tag),
        .rvalid_o (vic_valid),
        .rdirty_o (vic_dirty)
    );

    always_comb begin
        cpu_ready   = 1'b0;
        cpu_rdata   = '0;
        sram_we     = 1'b0;
        sram_wdata  = '0;
        tag_we      = 1'b0;
        tag_dirty   = 1'b0;
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        if (cpu_we) begin
                            sram_we         = 1'b1;
                            sram_wdata      = sram_rdata;
                            sram_wdata[off] = cpu_wdata;
                            tag_we          = 1'b1;
                            tag_dirty       = 1'b1;
                        end else begin
                            cpu_rdata = sram_rdata[off];
                        end
                    end else if (vic_valid && vic_dirty) begin
                        state_d     = WRITEBACK;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = line_addr(vic_tag, idx);
                        mem_wdata_d = sram_rdata;
                    end else begin
                        state_d    = ALLOCATE;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = line_addr(cpu_tag, idx);
                    end
                end
            end
            WRITEBACK: begin
                if (mem_ack) begin
                    state_d     = ALLOCATE;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = line_addr(cpu_tag, idx);
                    mem_wdata_d = '0;
                end
            end
            ALLOCATE: begin
                if (mem_ack) begin
                    sram_we    = 1'b1;
                    sram_wdata = mem_rdata;
                    if (cpu_we) sram_wdata[off] = cpu_wdata;
                    tag_we     = 1'b1;
                    tag_dirty  = cpu_we;
                    state_d    = IDLE;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    mem_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] access_cnt_q, access_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic [31:0] wb_cnt_q, wb_cnt_d;

    always_comb begin
        access_cnt_d = access_cnt_q + {31'd0, cpu_ready};
        miss_cnt_d   = miss_cnt_q + {31'd0, (state_q == IDLE) && (state_d != IDLE)};
        wb_cnt_d     = wb_cnt_q + {31'd0, (state_q == WRITEBACK) && mem_ack};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            access_cnt_q <= '0;
            miss_cnt_q   <= '0;
            wb_cnt_q     <= '0;
        end else begin
            access_cnt_q <= access_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            wb_cnt_q     <= wb_cnt_d;
        end
    end

    assign access_cnt = access_cnt_q;
    assign miss_cnt   = miss_cnt_q;
    assign wb_cnt     = wb_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller with a behavioural line SRAM and a
// hand-driven DRAM that acks three cycles after each request.
module tb_dcache_controller;
    import dcache_pkg::*;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               cpu_req, cpu_we;
    logic [ADDR_W-1:0]  cpu_addr;
    logic [WORD_W-1:0]  cpu_wdata, cpu_rdata;
    logic               cpu_ready, sram_we;
    logic [INDEX_W-1:0] sram_index;
    line_t              sram_wdata, sram_rdata;
    logic               mem_req, mem_we, mem_ack;
    logic [ADDR_W-1:0]  mem_addr;
    line_t              mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
    logic [31:0]        access_cnt, miss_cnt, wb_cnt;
`endif

    int total = 0;
    int bad   = 0;

    line_t sram_mem [LINES];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (sram_we) sram_mem[sram_index] <= sram_wdata;
    end
    assign sram_rdata = sram_mem[sram_index];

    dcache_controller dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .sram_we    (sram_we),
        .sram_index (sram_index),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef DCACHE_STATS_EN
        ,
        .access_cnt (access_cnt),
        .miss_cnt   (miss_cnt),
        .wb_cnt     (wb_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cpu(input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
        @(negedge clock);
        cpu_req   = req;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        #1;
    endtask

    // Waits (bounded) for mem_req, checks the request, then raises mem_ack on the third cycle.
    task automatic dram(input string tag, input logic exp_we, input logic [31:0] exp_addr,
                        input line_t rdata, output line_t wseen);
        int n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        chk({tag, "_req"}, mem_req, 1'b1);
        chk({tag, "_we"}, mem_we, exp_we);
        chk({tag, "_addr"}, mem_addr, exp_addr);
        wseen = mem_wdata;
        repeat (2) @(negedge clock);
        mem_rdata = rdata;
        mem_ack   = 1'b1;
        #1;
    endtask

    task automatic ack_low;
        @(negedge clock);
        mem_ack = 1'b0;
        #1;
    endtask

    line_t la, lb, lc, ld, exp_l, ws;

    initial begin
        la = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        lb = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        lc = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        ld = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
        reset_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #13;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_ready", cpu_ready, 1'b0);
        chk("rst_swe", sram_we, 1'b0);
        chk("rst_swdata", sram_wdata, 128'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // Cold load 0x40
        cpu(1'b1, 1'b0, 32'h40, 32'h0);
        chk("t1_miss_ready", cpu_ready, 1'b0);
        dram("t1_alloc", 1'b0, 32'h40, la, ws);
        chk("t1_fill_we", sram_we, 1'b1);
        chk("t1_fill_idx", sram_index, 4'd4);
        chk("t1_fill_data", sram_wdata, la);
        chk("t1_fill_ready", cpu_ready, 1'b0);
        ack_low();
        chk("t1_hit_ready", cpu_ready, 1'b1);
        chk("t1_hit_rdata", cpu_rdata, 32'hA0);
        chk("t1_req_drop", mem_req, 1'b0);

        // Store hit 0x44, then read it back
        cpu(1'b1, 1'b1, 32'h44, 32'hDEADBEEF);
        exp_l = la;
        exp_l[1] = 32'hDEADBEEF;
        chk("t2_ready", cpu_ready, 1'b1);
        chk("t2_swe", sram_we, 1'b1);
        chk("t2_swdata", sram_wdata, exp_l);
        chk("t2_no_req", mem_req, 1'b0);
        cpu(1'b1, 1'b0, 32'h44, 32'h0);
        chk("t2_rd_ready", cpu_ready, 1'b1);
        chk("t2_rd_data", cpu_rdata, 32'hDEADBEEF);

        // Dirty conflict miss 0x140
        cpu(1'b1, 1'b0, 32'h140, 32'h0);
        chk("t3_miss_ready", cpu_ready, 1'b0);
        dram("t3_wb", 1'b1, 32'h40, '0, ws);
        chk("t3_wb_data", ws, exp_l);
        chk("t3_wb_swe", sram_we, 1'b0);
        chk("t3_wb_ready", cpu_ready, 1'b0);
        ack_low();
        dram("t3_alloc", 1'b0, 32'h140, lb, ws);
        chk("t3_fill_data", sram_wdata, lb);
        ack_low();
        chk("t3_hit_ready", cpu_ready, 1'b1);
        chk("t3_hit_rdata", cpu_rdata, 32'hB0);
`ifdef DCACHE_STATS_EN
        @(negedge clock);
        cpu_req = 1'b0;
        #1;
        chk("st_access", access_cnt, 32'd4);
        chk("st_miss", miss_cnt, 32'd2);
        chk("st_wb", wb_cnt, 32'd1);
`endif

        // Store miss 0x288 into clean line, then evicting load 0x88
        cpu(1'b1, 1'b1, 32'h288, 32'h12345678);
        chk("t4_miss_ready", cpu_ready, 1'b0);
        dram("t4_alloc", 1'b0, 32'h280, lc, ws);
        exp_l = lc;
        exp_l[2] = 32'h12345678;
        chk("t4_fill_idx", sram_index, 4'd8);
        chk("t4_fill_data", sram_wdata, exp_l);
        ack_low();
        chk("t4_hit_ready", cpu_ready, 1'b1);
        chk("t4_hit_swe", sram_we, 1'b1);
        cpu(1'b1, 1'b0, 32'h88, 32'h0);
        chk("t4_ld_ready", cpu_ready, 1'b0);
        dram("t4_wb", 1'b1, 32'h280, '0, ws);
        chk("t4_wb_data", ws, exp_l);
        ack_low();
        dram("t4_alloc2", 1'b0, 32'h80, ld, ws);
        ack_low();
        chk("t4_ld_hit", cpu_ready, 1'b1);
        chk("t4_ld_rdata", cpu_rdata, 32'hD2);

        // Reset during ALLOCATE, then a formerly resident line misses
        cpu(1'b1, 1'b0, 32'h300, 32'h0);
        @(negedge clock);
        #1;
        chk("t5_req", mem_req, 1'b1);
        chk("t5_addr", mem_addr, 32'h300);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_req", mem_req, 1'b0);
        chk("t5_rst_ready", cpu_ready, 1'b0);
        cpu_req = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        cpu(1'b1, 1'b0, 32'h80, 32'h0);
        chk("t5_reload_ready", cpu_ready, 1'b0);
        dram("t5_realloc", 1'b0, 32'h80, ld, ws);
        ack_low();
        chk("t5_reload_hit", cpu_ready, 1'b1);
        chk("t5_reload_rdata", cpu_rdata, 32'hD0);

        @(negedge clock);
        cpu_req = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
